mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit for the multicycle ALU stage. Takes the A/B operand

---
 rtl/alu_pkg.sv | 19 +
 rtl/mdu_negate.sv | 13 +
 rtl/mult_div_unit.sv | 137 +++++++++++++
 tb/tb_mult_div_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the multicycle ALU stage: multiply/divide opcodes and
// the mult_div_unit control states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement: o_val = i_neg ? -i_val : i_val.
// Used for operand magnitudes and for result sign fix-up.
module mdu_negate #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes,
// one bit per cycle, with a final sign fix-up cycle.
module mult_div_unit
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic         div_zero,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CNT_W = $clog2(W);

  state_e         r_state;
  logic [CNT_W-1:0] r_cnt;
  logic           r_is_div;
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_bz;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_p;
  logic           r_busy;
  logic           r_done;
  logic           r_dz;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;

  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic [W:0]     w_add_a;
  logic [W:0]     w_add_b;
  logic [W+1:0]   w_sum;
  logic           w_ok;
  logic [2*W-1:0] w_p_nxt;
  logic [2*W-1:0] w_fix_p;
  logic [W-1:0]   w_rem_src;
  logic [W-1:0]   w_fix_r;
  logic [W-1:0]   w_fix_q;

  mdu_negate #(.W(W)) u_abs_a (.i_neg(op[0] & op_a[W-1]), .i_val(op_a), .o_val(w_abs_a));
  mdu_negate #(.W(W)) u_abs_b (.i_neg(op[0] & op_b[W-1]), .i_val(op_b), .o_val(w_abs_b));

  // Shared W+1-bit add/sub: MUL adds the multiplicand into the upper half,
  // DIV subtracts the divisor from the shifted remainder (carry-out = no borrow).
  assign w_add_a = r_is_div ? r_p[2*W-1:W-1] : {1'b0, r_p[2*W-1:W]};
  assign w_add_b = r_is_div ? ~{1'b0, r_b} : (r_p[0] ? {1'b0, r_a} : '0);
  assign w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(W+1){1'b0}}, r_is_div};
  assign w_ok    = w_sum[W+1];

  assign w_p_nxt = r_is_div
    ? {(w_ok ? w_sum[W-1:0] : r_p[2*W-2:W-1]), r_p[W-2:0], w_ok}
    : {w_sum[W:0], r_p[W-1:1]};

  // Divide-by-zero reports the original dividend: restoring |a| with its sign.
  assign w_rem_src = r_bz ? r_a : r_p[2*W-1:W];

  mdu_negate #(.W(2*W)) u_fix_p (.i_neg(r_neg_q), .i_val(r_p),        .o_val(w_fix_p));
  mdu_negate #(.W(W))   u_fix_q (.i_neg(r_neg_q), .i_val(r_p[W-1:0]), .o_val(w_fix_q));
  mdu_negate #(.W(W))   u_fix_r (.i_neg(r_neg_r), .i_val(w_rem_src),  .o_val(w_fix_r));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bz     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_p      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state  <= ST_CALC;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_is_div <= op[1];
            r_neg_q  <= op[0] & (op_a[W-1] ^ op_b[W-1]);
            r_neg_r  <= op[0] & op_a[W-1];
            r_bz     <= (op_b == '0);
            r_a      <= w_abs_a;
            r_b      <= w_abs_b;
            // Upper half starts clear; lower half holds the bits consumed
            // (multiplier) or produced into (dividend -> quotient).
            r_p      <= {{W{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          r_p   <= w_p_nxt;
          r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (r_cnt == CNT_W'(W-1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (r_is_div) begin
            r_dz <= r_bz;
            r_lo <= r_bz ? '1 : w_fix_q;
            r_hi <= w_fix_r;
          end else begin
            r_dz <= 1'b0;
            {r_hi, r_lo} <= w_fix_p;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (W=32): directed table, random ops
// against a 64-bit arithmetic reference, and hand-written timing corner cases.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  mult_div_unit #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference computed with plain 64-bit arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic dz);
    logic [63:0] p;
    longint sa, sb, sq, sr;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          l = 32'hFFFFFFFF; h = a; dz = 1'b1;
        end else if (o == 2'b10) begin
          l = a / b; h = a % b;
        end else begin
          sq = sa / sb; sr = sa % sb;
          l = sq[31:0]; h = sr[31:0];
        end
      end
    endcase
  endfunction

  // Drives a launch now; returns the result at the done pulse, the edge count
  // from acceptance to done (0 on timeout) and busy-low samples seen meanwhile.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output logic dz,
                        output int lat, output int bl);
    op = o; op_a = a; op_b = b; start = 1'b1;
    lat = 0; bl = 0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (!busy) bl++;
      @(posedge clk);
      #1;
      if (done) begin lat = n; break; end
    end
    h = hi; l = lo; dz = div_zero;
    if (lat == W + 1 && busy) bl++;
  endtask

  task automatic run_chk(input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
    logic [31:0] h, l, eh, el;
    logic dz, edz;
    int lat, bl;
    model(o, a, b, eh, el, edz);
    run_op(o, a, b, h, l, dz, lat, bl);
    chk({nm, ".lat"}, 64'(lat), 64'(W + 1));
    chk({nm, ".hi"}, {32'd0, h}, {32'd0, eh});
    chk({nm, ".lo"}, {32'd0, l}, {32'd0, el});
    chk({nm, ".dz"}, {63'd0, dz}, {63'd0, edz});
    chk({nm, ".busy"}, 64'(bl), 64'd0);
  endtask

  initial begin
    logic [31:0] h, l, ph, pl, a, b;
    logic dz;
    int lat, bl;
    logic [1:0] o;

    tbl[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[1]  = '{2'b01, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
    tbl[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[3]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    tbl[4]  = '{2'b10, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
    tbl[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tbl[6]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    tbl[7]  = '{2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    tbl[8]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tbl[9]  = '{2'b10, 32'd5,        32'd10,       32'd5,        32'd0,        1'b0};
    tbl[10] = '{2'b00, 32'd0,        32'h12345678, 32'd0,        32'd0,        1'b0};
    tbl[11] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0};

    #12;
    chk("rst.busy", {63'd0, busy}, 64'd0);
    chk("rst.done", {63'd0, done}, 64'd0);
    chk("rst.dz",   {63'd0, div_zero}, 64'd0);
    chk("rst.hilo", {hi, lo}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      repeat (2) @(negedge clk);
      chk($sformatf("t%0d.idle", i), {62'd0, busy, done}, 64'd0);
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, h, l, dz, lat, bl);
      chk($sformatf("t%0d.lat", i), 64'(lat), 64'(W + 1));
      chk($sformatf("t%0d.hilo", i), {h, l}, {tbl[i].hi, tbl[i].lo});
      chk($sformatf("t%0d.dz", i), {63'd0, dz}, {63'd0, tbl[i].dz});
      chk($sformatf("t%0d.busy", i), 64'(bl), 64'd0);
    end

    // Random ops, with operand corner values mixed in; mostly back-to-back.
    for (int i = 0; i < 48; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      if (i % 5 == 0) @(negedge clk);
      run_chk($sformatf("r%0d", i), o, a, b);
    end

    // start pulsed at E5 of a MUL is ignored; outputs hold meanwhile.
    @(negedge clk);
    ph = hi; pl = lo;
    fork
      run_op(2'b01, 32'hFFFFFFF9, 32'd6, h, l, dz, lat, bl);
      begin
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2 start = 1'b1; op = 2'b10; op_a = 32'd9; op_b = 32'd0;
        @(posedge clk);
        #2 start = 1'b0;
        chk("ign.hold", {hi, lo}, {ph, pl});
        chk("ign.busy", {63'd0, busy}, 64'd1);
      end
    join
    chk("ign.lat", 64'(lat), 64'(W + 1));
    chk("ign.hilo", {h, l}, {32'hFFFFFFFF, 32'hFFFFFFD6});
    chk("ign.dz", {63'd0, dz}, 64'd0);

    // start in the DONE cycle is accepted with no idle gap.
    run_op(2'b10, 32'd1000, 32'd9, h, l, dz, lat, bl);
    chk("b2b.lat", 64'(lat), 64'(W + 1));
    chk("b2b.hilo", {h, l}, {32'd1, 32'd111});
    chk("b2b.busy", 64'(bl), 64'd0);

    // Reset mid-divide clears everything at once.
    @(negedge clk);
    op = 2'b11; op_a = 32'hFFFFFF9C; op_b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.busy", {63'd0, busy}, 64'd0);
    chk("arst.done", {63'd0, done}, 64'd0);
    chk("arst.hilo", {hi, lo}, 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("arst.nodone", {63'd0, done}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_chk("post_rst", 2'b11, 32'hFFFFFF9C, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
